// File: rtl/dest_drain_ctrl.sv
// Drains the two destination FIFOs round-robin onto one lane-tagged valid/ready
// stream, one word per transfer, with per-lane wrap-around delivered-word counters.
module dest_drain_ctrl #(
  parameter int DATA_SIZE = 6,
  parameter int RD_LAT    = 1,
  parameter int FLAG_LAT  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 empty_0,
  input  logic                 empty_1,
  input  logic [DATA_SIZE-1:0] data_in_0,
  input  logic [DATA_SIZE-1:0] data_in_1,
  input  logic                 out_ready,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 dest_out,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     count_0,
  output logic [CNT_W-1:0]     count_1,
  output logic                 busy
);

  localparam int GW = (FLAG_LAT < 1) ? 1 : $clog2(FLAG_LAT + 1);
  localparam int WW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(FLAG_LAT);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(RD_LAT);
  localparam logic [GW-1:0] GUARD_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
  localparam logic [WW-1:0] WAIT_ZERO  = {WW{1'b0}};
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_SIZE-1:0] DATA_ZERO = {DATA_SIZE{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_sel;
  logic                 r_last_lane;
  logic [GW-1:0]        r_guard_0;
  logic [GW-1:0]        r_guard_1;
  logic [WW-1:0]        r_wait_cnt;
  logic                 r_pop_d0;
  logic                 r_pop_d1;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_dest_out;
  logic                 r_valid_out;
  logic [CNT_W-1:0]     r_count_0;
  logic [CNT_W-1:0]     r_count_1;
  logic                 r_busy;

  logic                 w_elig_0;
  logic                 w_elig_1;
  logic                 w_any_elig;
  logic                 w_next_sel;
  logic [DATA_SIZE-1:0] w_sel_data;

  // Round-robin pick: on a tie the lane that did not go last wins.
  function automatic logic pick_lane(input logic e0, input logic e1, input logic last);
    logic lane;
    if (e0 && e1) begin
      lane = ~last;
    end else if (e1) begin
      lane = 1'b1;
    end else begin
      lane = 1'b0;
    end
    return lane;
  endfunction

  // Eligibility, next lane selection and read-data mux.
  always_comb begin
    w_elig_0   = ~empty_0 & (r_guard_0 == GUARD_ZERO);
    w_elig_1   = ~empty_1 & (r_guard_1 == GUARD_ZERO);
    w_any_elig = w_elig_0 | w_elig_1;
    w_next_sel = pick_lane(w_elig_0, w_elig_1, r_last_lane);
    if (r_sel) begin
      w_sel_data = data_in_1;
    end else begin
      w_sel_data = data_in_0;
    end
  end

  // Empty flags lag a pop by FLAG_LAT cycles, so a lane is masked that long after its pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_guard_0 <= GUARD_ZERO;
      r_guard_1 <= GUARD_ZERO;
    end else begin
      if (r_state == S_POP && r_sel == 1'b0) begin
        r_guard_0 <= GUARD_LOAD;
      end else if (r_guard_0 != GUARD_ZERO) begin
        r_guard_0 <= r_guard_0 - GUARD_ONE;
      end else begin
        r_guard_0 <= r_guard_0;
      end
      if (r_state == S_POP && r_sel == 1'b1) begin
        r_guard_1 <= GUARD_LOAD;
      end else if (r_guard_1 != GUARD_ZERO) begin
        r_guard_1 <= r_guard_1 - GUARD_ONE;
      end else begin
        r_guard_1 <= r_guard_1;
      end
    end
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_last_lane <= 1'b1;
      r_wait_cnt  <= WAIT_ZERO;
      r_pop_d0    <= 1'b0;
      r_pop_d1    <= 1'b0;
      r_data_out  <= DATA_ZERO;
      r_dest_out  <= 1'b0;
      r_valid_out <= 1'b0;
      r_count_0   <= CNT_ZERO;
      r_count_1   <= CNT_ZERO;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init && w_any_elig) begin
            r_sel    <= w_next_sel;
            r_pop_d0 <= ~w_next_sel;
            r_pop_d1 <= w_next_sel;
            r_busy   <= 1'b1;
            r_state  <= S_POP;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_POP: begin
          r_pop_d0    <= 1'b0;
          r_pop_d1    <= 1'b0;
          r_last_lane <= r_sel;
          r_wait_cnt  <= WAIT_LOAD;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - WAIT_ONE;
          // The last WAIT cycle is the one where the FIFO read data is valid.
          if (r_wait_cnt == WAIT_ONE) begin
            r_data_out  <= w_sel_data;
            r_dest_out  <= r_sel;
            r_valid_out <= 1'b1;
            if (r_sel) begin
              r_count_1 <= r_count_1 + CNT_ONE;
            end else begin
              r_count_0 <= r_count_0 + CNT_ONE;
            end
            r_state <= S_HOLD;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_valid_out <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_HOLD;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_pop_d0    <= 1'b0;
          r_pop_d1    <= 1'b0;
          r_valid_out <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign pop_d0    = r_pop_d0;
  assign pop_d1    = r_pop_d1;
  assign data_out  = r_data_out;
  assign dest_out  = r_dest_out;
  assign valid_out = r_valid_out;
  assign count_0   = r_count_0;
  assign count_1   = r_count_1;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dest_drain_ctrl.sv
// Randomized scoreboard bench for dest_drain_ctrl: the bench plays the packet-switch
// core (FIFOs with lagging empty flags) and predicts pops, timing and delivered words.
module tb_dest_drain_ctrl;

  localparam int DW = 6;
  localparam int RL = 1;
  localparam int FL = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, init, empty_0, empty_1, out_ready;
  logic [DW-1:0] data_in_0, data_in_1, data_out;
  logic          pop_d0, pop_d1, dest_out, valid_out, busy;
  logic [CW-1:0] count_0, count_1;

  always #5 clk = ~clk;

  dest_drain_ctrl #(.DATA_SIZE(DW), .RD_LAT(RL), .FLAG_LAT(FL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .empty_0(empty_0), .empty_1(empty_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .out_ready(out_ready),
    .pop_d0(pop_d0), .pop_d1(pop_d1), .data_out(data_out), .dest_out(dest_out),
    .valid_out(valid_out), .count_0(count_0), .count_1(count_1), .busy(busy)
  );

  typedef struct {
    logic          lane;
    logic [DW-1:0] word;
    logic [CW-1:0] cnt;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t          sb[$];
  logic [DW-1:0] env_q0[$], env_q1[$];   // what the core FIFOs really hold
  logic [DW-1:0] mod_q0[$], mod_q1[$];   // reference model's copy
  int            sh0[FL+1], sh1[FL+1];   // occupancy history driving stale empty flags

  bit            m_busy;
  int            m_valid_from;
  bit            m_last;
  int            m_lastpop[2];
  logic [CW-1:0] m_cnt[2];
  int            exp_pop;

  bit            pend_v;
  int            pend_cyc;
  bit            pend_lane;
  logic [DW-1:0] pend_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_valid_from = 0;
    m_last = 1'b1;
    m_lastpop[0] = -100;
    m_lastpop[1] = -100;
    m_cnt[0] = '0;
    m_cnt[1] = '0;
    sb.delete();
    exp_pop = -1;
    pend_v = 1'b0;
  endtask

  task automatic push_word(input int lane, input logic [DW-1:0] w);
    if (lane == 0) begin
      env_q0.push_back(w);
      mod_q0.push_back(w);
    end else begin
      env_q1.push_back(w);
      mod_q1.push_back(w);
    end
  endtask

  // One clock: check this cycle, emulate the core, then drive the next cycle's inputs.
  task automatic step(input bit rst, input bit ini, input bit rdy);
    int lane;
    logic [DW-1:0] w;
    bit e0, e1;
    @(posedge clk);
    #1;
    cyc++;
    chk("pop_d0", {31'd0, pop_d0}, {31'd0, exp_pop == 0});
    chk("pop_d1", {31'd0, pop_d1}, {31'd0, exp_pop == 1});
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_busy && (cyc >= m_valid_from)});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (exp_pop >= 0) begin
      lane = exp_pop;
      w = '0;
      if (lane == 0 && mod_q0.size() != 0) w = mod_q0.pop_front();
      if (lane == 1 && mod_q1.size() != 0) w = mod_q1.pop_front();
      m_cnt[lane] = m_cnt[lane] + 1'b1;
      sb.push_back('{lane[0], w, m_cnt[lane]});
    end
    exp_pop = -1;

    for (int i = FL; i > 0; i--) begin
      sh0[i] = sh0[i-1];
      sh1[i] = sh1[i-1];
    end
    sh0[0] = env_q0.size();
    sh1[0] = env_q1.size();
    empty_0 = (sh0[FL] == 0);
    empty_1 = (sh1[FL] == 0);

    data_in_0 = DW'($urandom);
    data_in_1 = DW'($urandom);
    if (pend_v && pend_cyc == cyc) begin
      if (pend_lane) data_in_1 = pend_word;
      else data_in_0 = pend_word;
      pend_v = 1'b0;
    end
    if (pop_d0) begin
      chk("d0_nonempty_at_pop", {31'd0, env_q0.size() != 0}, 32'd1);
      if (env_q0.size() != 0) begin
        pend_v = 1'b1; pend_cyc = cyc + RL; pend_lane = 1'b0; pend_word = env_q0.pop_front();
      end
    end
    if (pop_d1) begin
      chk("d1_nonempty_at_pop", {31'd0, env_q1.size() != 0}, 32'd1);
      if (env_q1.size() != 0) begin
        pend_v = 1'b1; pend_cyc = cyc + RL; pend_lane = 1'b1; pend_word = env_q1.pop_front();
      end
    end

    reset = rst;
    init = ini;
    out_ready = rdy;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (ini) begin
        e0 = !empty_0 && (cyc >= m_lastpop[0] + FL + 1);
        e1 = !empty_1 && (cyc >= m_lastpop[1] + FL + 1);
        if (e0 && e1) exp_pop = m_last ? 0 : 1;
        else if (e0) exp_pop = 0;
        else if (e1) exp_pop = 1;
        if (exp_pop >= 0) begin
          m_busy = 1'b1;
          m_valid_from = cyc + 1 + RL + 1;
          m_lastpop[exp_pop] = cyc + 1;
          m_last = exp_pop[0];
        end
      end
    end else if (cyc >= m_valid_from && rdy) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || m_busy || exp_pop >= 0 || env_q0.size() != 0 ||
            env_q1.size() != 0) && n < bound) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    if (n >= bound) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every accepted output word must be the next predicted one.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && valid_out === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {31'd0, valid_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data_out", {26'd0, data_out}, {26'd0, e.word});
        chk("dest_out", {31'd0, dest_out}, {31'd0, e.lane});
        chk("lane_count", {24'd0, (e.lane ? count_1 : count_0)}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; init = 1'b0; out_ready = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; data_in_0 = '0; data_in_1 = '0;
    for (int i = 0; i <= FL; i++) begin sh0[i] = 0; sh1[i] = 0; end
    model_reset();

    do_reset(3);
    chk("rst_data_out", {26'd0, data_out}, 32'd0);
    chk("rst_dest_out", {31'd0, dest_out}, 32'd0);
    chk("rst_count_0", {24'd0, count_0}, 32'd0);
    chk("rst_count_1", {24'd0, count_1}, 32'd0);

    // single D0 word
    push_word(0, 6'h15);
    drain(100);
    chk("t1_count_0", {24'd0, count_0}, 32'd1);
    chk("t1_count_1", {24'd0, count_1}, 32'd0);
    chk("t1_data_held", {26'd0, data_out}, 32'h15);

    // both lanes loaded: alternating pops every 4 cycles
    do_reset(FL + 2);
    for (int i = 0; i < 4; i++) begin
      push_word(0, DW'($urandom));
      push_word(1, DW'($urandom));
    end
    drain(200);
    chk("t2_count_0", {24'd0, count_0}, 32'd4);
    chk("t2_count_1", {24'd0, count_1}, 32'd4);

    // downstream stall in HOLD
    push_word(1, 6'h2a);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0);
    chk("t3_valid_stalled", {31'd0, valid_out}, 32'd1);
    chk("t3_data_stalled", {26'd0, data_out}, 32'h2a);
    drain(100);

    // stale empty flag after a lone D0 word, then a burst on D0 only
    push_word(0, DW'($urandom));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_word(0, DW'($urandom));
    drain(200);

    // reset while the transfer waits for read data
    do_reset(FL + 2);
    push_word(0, 6'h3c);
    push_word(0, 6'h07);
    n = 0;
    while (pop_d0 !== 1'b1 && n < 50) begin step(1'b0, 1'b1, 1'b1); n++; end
    if (n >= 50) chk("t5_pop_timeout", 32'd0, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_valid_after_rst", {31'd0, valid_out}, 32'd0);
    chk("t5_count_0_after_rst", {24'd0, count_0}, 32'd0);
    chk("t5_data_after_rst", {26'd0, data_out}, 32'd0);
    do_reset(FL);
    drain(100);
    chk("t5_count_0_final", {24'd0, count_0}, 32'd1);

    // init dropped mid-transfer
    for (int i = 0; i < 3; i++) begin
      push_word(0, DW'($urandom));
      push_word(1, DW'($urandom));
    end
    n = 0;
    while (pop_d0 !== 1'b1 && pop_d1 !== 1'b1 && n < 50) begin step(1'b0, 1'b1, 1'b1); n++; end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
    chk("t6_idle_after_init_low", {31'd0, busy}, 32'd0);
    drain(200);

    // 256 D1 words: count_1 wraps to 0
    do_reset(FL + 2);
    for (int i = 0; i < 256; i++) push_word(1, DW'($urandom));
    drain(3000);
    chk("t7_count_1_wrap", {24'd0, count_1}, 32'd0);
    chk("t7_count_0", {24'd0, count_0}, 32'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 2) push_word(0, DW'($urandom));
      if ($urandom_range(0, 9) < 2) push_word(1, DW'($urandom));
    end
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dest_drain_ctrl.md
Name: dest_drain_ctrl

Overview:
- Downstream consumer of the packet-switch core.
- Watches the registered empty flags of the two destination FIFOs (D0, D1) and issues single-cycle pops to them, arbitrating round-robin between lanes.
- Captures the returned word and presents it on a single valid/ready output stream tagged with its lane.
- Keeps per-lane wrap-around word counters for the bench and scoreboards.

Parameters:
- DATA_SIZE, 6, width of data words.
- RD_LAT, 1, cycles from pop-asserted cycle to the cycle data_in_x is valid (1..3).
- FLAG_LAT, 2, cycles after a pop during which that lane's empty flag is stale and the lane is ineligible (1..7).
- CNT_W, 8, width of per-lane word counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- init  in  1  enable; 0 = finish current transfer, start no new pop
- empty_0  in  1  D0 FIFO empty (registered, from core)
- empty_1  in  1  D1 FIFO empty (registered, from core)
- data_in_0  in  DATA_SIZE  D0 FIFO read data
- data_in_1  in  DATA_SIZE  D1 FIFO read data
- out_ready  in  1  downstream accepts data_out this cycle
- pop_d0  out  1  pop strobe to D0
- pop_d1  out  1  pop strobe to D1
- data_out  out  DATA_SIZE  captured word
- dest_out  out  1  lane of data_out (0 = D0, 1 = D1)
- valid_out  out  1  data_out/dest_out valid
- count_0  out  CNT_W  words delivered from D0
- count_1  out  CNT_W  words delivered from D1
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (sampled at rising edge):
  - state = IDLE; pop_d0/pop_d1 = 0; data_out = 0; dest_out = 0; valid_out = 0; count_0 = count_1 = 0; busy = 0.
  - last_lane = 1, so lane 0 wins the first tie; both guard counters = 0.
  - Reset mid-transfer abandons the transfer; no count increment; a popped word is discarded.
- FSM states: IDLE, POP, WAIT, HOLD. Pops are Moore outputs, decoded from state POP and the selected lane.
- Lane x is eligible when empty_x = 0 and guard_x = 0.
- IDLE:
  - If init = 1 and any lane is eligible, select a lane and go to POP.
  - Both eligible: select the lane != last_lane. One eligible: select it.
- POP (exactly 1 cycle):
  - pop_d<sel> = 1; guard_sel loaded with FLAG_LAT; last_lane = sel.
  - Go to WAIT with wait count RD_LAT.
- WAIT:
  - Decrement the wait count each cycle.
  - In the cycle where data_in_sel is valid (RD_LAT cycles after POP), the edge loads data_out = data_in_sel, dest_out = sel, valid_out = 1, count_sel += 1; then go to HOLD.
- HOLD:
  - valid_out = 1; data_out and dest_out held stable.
  - When out_ready = 1, the edge clears valid_out and the state goes to IDLE. data_out and dest_out hold their last value.
- Guard counters: decrement each cycle while nonzero, independent of state.
- Timeline, RD_LAT = 1: POP at T, capture edge at end of T+1, valid_out high from T+2, earliest next POP at T+4 with out_ready = 1 at T+2. Peak throughput is 1 word per 4 cycles.
- Exactly one pop per transfer. Never both pops in one cycle. Never a pop outside POP state.
- Counters wrap from 2^CNT_W-1 to 0 with no flag.
- init falling during POP, WAIT or HOLD: the transfer completes normally, then the FSM stays in IDLE.
- out_ready high outside HOLD: ignored.
- Empty flag rising during WAIT: ignored; the pop has already been committed.

Test Plan:
- Reset then init = 1, empty_0 = 0, empty_1 = 1, data_in_0 = 6'h15, out_ready = 1 → pop_d0 high 1 cycle at T; valid_out = 1, data_out = 6'h15, dest_out = 0 at T+2; count_0 = 1; pop_d1 never asserted.
- Both lanes non-empty for 8 transfers, out_ready = 1 → pop order D0, D1, D0, D1, …; count_0 = count_1 = 4; pops spaced 4 cycles apart.
- out_ready = 0 for 10 cycles in HOLD → valid_out held, data_out stable, no new pop; out_ready = 1 → IDLE next cycle.
- empty_0 stays 0 for FLAG_LAT cycles after a D0 pop with FLAG_LAT = 5, D1 empty → no second D0 pop until guard_0 expires.
- reset asserted in WAIT → next cycle all outputs 0, state IDLE, counters 0; init toggled low mid-transfer → transfer completes, no further pops.
- 256 D1 words with CNT_W = 8 → count_1 wraps to 0.
